// File: rtl/reg_file_pkg.sv
// Shared register-file constants: bus widths and
// well-known register numbers used by decode and tests.
package reg_file_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: reset/enable/zero gating,
// then same-cycle write bypass, then stored value.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          rst,
    input  logic          read_en,
    input  logic [AW-1:0] read_addr,
    input  logic          write_en,
    input  logic [AW-1:0] write_addr,
    input  logic [DW-1:0] write_data,
    input  logic [DW-1:0] reg_data,
    output logic [DW-1:0] read_data
);

    logic zero_sel;
    logic byp_sel;

    assign zero_sel = rst || !read_en
                   || (read_addr == AW'(REG_ZERO));
    assign byp_sel  = write_en && (write_addr == read_addr);

    // Priority select; zero gating dominates the bypass.
    always_comb begin
        read_data = '0;
        if (zero_sel) begin
            read_data = '0;
        end else if (byp_sel) begin
            read_data = write_data;
        end else begin
            read_data = reg_data;
        end
    end

endmodule

// File: rtl/reg_file.sv
// ID-stage 32x32 register file, $0 hardwired to zero,
// two combinational read ports with WB->ID bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DW  = DATA_W,
    parameter int AW  = ADDR_W,
    parameter int NUM = REG_NUM
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          read_en_1,
    input  logic [AW-1:0] read_addr_1,
    output logic [DW-1:0] read_data_1,
    input  logic          read_en_2,
    input  logic [AW-1:0] read_addr_2,
    output logic [DW-1:0] read_data_2,
    input  logic          write_en,
    input  logic [AW-1:0] write_addr,
    input  logic [DW-1:0] write_data
);

    logic [DW-1:0] regs_q [NUM];
    logic [DW-1:0] regs_d [NUM];
    logic          wr_ok;

    assign wr_ok = write_en && (write_addr != AW'(REG_ZERO));

    // Next-state: reset clears all and drops the write.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_ok) begin
            regs_d[write_addr] = write_data;
        end
    end

    // Register storage update.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    reg_read_port #(.DW(DW), .AW(AW)) u_rd1 (
        .rst        (rst),
        .read_en    (read_en_1),
        .read_addr  (read_addr_1),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .reg_data   (regs_q[read_addr_1]),
        .read_data  (read_data_1)
    );

    reg_read_port #(.DW(DW), .AW(AW)) u_rd2 (
        .rst        (rst),
        .read_en    (read_en_2),
        .read_addr  (read_addr_2),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .reg_data   (regs_q[read_addr_2]),
        .read_data  (read_data_2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read,
// bypass, $0, enable gating, reset/write collision.
module tb_reg_file;
    import reg_file_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              read_en_1;
    logic [ADDR_W-1:0] read_addr_1;
    logic [DATA_W-1:0] read_data_1;
    logic              read_en_2;
    logic [ADDR_W-1:0] read_addr_2;
    logic [DATA_W-1:0] read_data_2;
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .read_en_1   (read_en_1),
        .read_addr_1 (read_addr_1),
        .read_data_1 (read_data_1),
        .read_en_2   (read_en_2),
        .read_addr_2 (read_addr_2),
        .read_data_2 (read_data_2),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
    endtask

    task automatic rd(input logic e1, input logic [ADDR_W-1:0] a1,
                      input logic e2, input logic [ADDR_W-1:0] a2);
        read_en_1   = e1;
        read_addr_1 = a1;
        read_en_2   = e2;
        read_addr_2 = a2;
    endtask

    initial begin
        rst        = 1'b1;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        rd(1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        // Reset dominates bypass on both ports.
        wr(5'd5, 32'h1111_2222);
        rd(1'b1, 5'd5, 1'b1, 5'd5);
        #1;
        chk("rst_rd1", read_data_1, 32'h0);
        chk("rst_rd2", read_data_2, 32'h0);
        tick();
        tick();
        write_en = 1'b0;
        rst      = 1'b0;
        #1;
        chk("post_rst_r5", read_data_1, 32'h0);

        // Preload r5, check, then reset clears it.
        wr(5'd5, 32'h1234_5678);
        tick();
        write_en = 1'b0;
        #1;
        chk("r5_load", read_data_1, 32'h1234_5678);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("r5_cleared", read_data_1, 32'h0);

        // Write then read on both ports.
        wr(5'd8, 32'hDEAD_BEEF);
        tick();
        write_en = 1'b0;
        rd(1'b1, 5'd8, 1'b1, 5'd8);
        #1;
        chk("r8_rd1", read_data_1, 32'hDEAD_BEEF);
        chk("r8_rd2", read_data_2, 32'hDEAD_BEEF);

        // Bypass before the edge, stored after it.
        rd(1'b1, 5'd9, 1'b1, 5'd9);
        wr(5'd9, 32'hCAFE_F00D);
        #1;
        chk("byp_rd1", read_data_1, 32'hCAFE_F00D);
        chk("byp_rd2", read_data_2, 32'hCAFE_F00D);
        tick();
        write_en = 1'b0;
        #1;
        chk("r9_stored", read_data_1, 32'hCAFE_F00D);

        // Bypass to one port only; other reads r8.
        rd(1'b1, 5'd9, 1'b1, 5'd8);
        wr(5'd9, 32'h0BAD_CAFE);
        #1;
        chk("byp_new_r9", read_data_1, 32'h0BAD_CAFE);
        chk("no_byp_r8", read_data_2, 32'hDEAD_BEEF);
        tick();
        write_en = 1'b0;

        // $0 stays zero during and after a write.
        rd(1'b1, 5'd0, 1'b1, 5'd0);
        wr(5'd0, 32'hFFFF_FFFF);
        #1;
        chk("r0_wr_rd1", read_data_1, 32'h0);
        chk("r0_wr_rd2", read_data_2, 32'h0);
        tick();
        write_en = 1'b0;
        #1;
        chk("r0_after", read_data_1, 32'h0);

        // Enable gating on port 2, and on a bypass.
        wr(5'd3, 32'hA5A5_A5A5);
        tick();
        write_en = 1'b0;
        rd(1'b1, 5'd9, 1'b0, 5'd3);
        #1;
        chk("en2_off", read_data_2, 32'h0);
        read_en_2 = 1'b1;
        #1;
        chk("en2_on", read_data_2, 32'hA5A5_A5A5);
        rd(1'b0, 5'd4, 1'b1, 5'd4);
        wr(5'd4, 32'h5555_AAAA);
        #1;
        chk("en1_off_byp", read_data_1, 32'h0);
        chk("en2_on_byp", read_data_2, 32'h5555_AAAA);
        tick();
        write_en = 1'b0;

        // Top register boundary.
        wr(REG_RA, 32'h8765_4321);
        tick();
        write_en = 1'b0;
        rd(1'b1, REG_RA, 1'b1, 5'd4);
        #1;
        chk("r31_rd", read_data_1, 32'h8765_4321);
        chk("r4_rd", read_data_2, 32'h5555_AAAA);

        // Reset and write collide: reset wins.
        rst = 1'b1;
        wr(REG_RA, 32'h0040_0008);
        tick();
        rst      = 1'b0;
        write_en = 1'b0;
        rd(1'b1, REG_RA, 1'b1, 5'd8);
        #1;
        chk("coll_r31", read_data_1, 32'h0);
        chk("coll_r8", read_data_2, 32'h0);

        // Disabled port with junk address stays zero.
        read_en_1   = 1'b0;
        read_addr_1 = 'x;
        #1;
        chk("en_off_x", read_data_1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end

endmodule
